// File: rtl/icache_bank_rr_arbiter_pkg.sv
// Shared types, default widths and helpers for the icache bank round-robin arbiter.
package icache_arb_pkg;

  localparam int unsigned DEFAULT_N_MASTER        = 4;
  localparam int unsigned DEFAULT_ADDR_WIDTH      = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH      = 128;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Width of a master index; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_bank_rr_arbiter_if.sv
// Fetch-side and bank-side handshake bundle of the icache bank arbiter.
interface icache_bank_rr_arbiter_if
  import icache_arb_pkg::*;
#(
  parameter int unsigned N_MASTER   = DEFAULT_N_MASTER,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [N_MASTER-1:0]                 req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] add_i;
  logic [N_MASTER-1:0]                 gnt_o;
  logic [N_MASTER-1:0]                 r_valid_o;
  logic [DATA_WIDTH-1:0]               r_rdata_o;
  logic                                req_o;
  logic [ADDR_WIDTH-1:0]               add_o;
  logic                                gnt_i;
  logic                                r_valid_i;
  logic [DATA_WIDTH-1:0]               r_rdata_i;

  // Arbiter view.
  modport slave (
    input  req_i, add_i, gnt_i, r_valid_i, r_rdata_i,
    output gnt_o, r_valid_o, r_rdata_o, req_o, add_o
  );

  // Environment view (fetch ports plus bank controller).
  modport master (
    output req_i, add_i, gnt_i, r_valid_i, r_rdata_i,
    input  gnt_o, r_valid_o, r_rdata_o, req_o, add_o
  );

endinterface

// File: rtl/bin_to_onehot.sv
// Binary index to one-hot decoder.
module bin_to_onehot #(
  parameter int unsigned BIN_WIDTH = 2
) (
  input  logic [BIN_WIDTH-1:0]        bin,
  output logic [(1<<BIN_WIDTH)-1:0]   onehot
);

  localparam int unsigned ONEHOT_W = 1 << BIN_WIDTH;

  // Shift a single set bit to the indexed position.
  assign onehot = ONEHOT_W'(1) << bin;

endmodule

// File: rtl/icache_bank_rr_arbiter_id_fifo.sv
// In-order FIFO of master IDs for accepted, not yet answered requests.
module icache_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/icache_bank_rr_arbiter.sv
// Round-robin share of one icache bank port between N_MASTER fetch ports,
// with in-order response routing through an ID FIFO.
module icache_bank_rr_arbiter
  import icache_arb_pkg::*;
#(
  parameter int unsigned N_MASTER        = DEFAULT_N_MASTER,
  parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      rst_n,
  icache_bank_rr_arbiter_if.slave   bus,
  output logic                      err_o
);

  localparam int unsigned ID_W = id_w(N_MASTER);

  arb_state_e          state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     sel_q;
  logic [ID_W-1:0]     rr_sel_c;
  logic [ID_W-1:0]     sel_c;
  logic [ID_W-1:0]     fifo_head;
  logic [N_MASTER-1:0] sel_oh;
  logic [N_MASTER-1:0] head_oh;
  logic                fifo_full;
  logic                fifo_empty;
  logic                req_c;
  logic                accept_c;
  logic                pop_c;
  logic                err_set_c;

  // Cyclic search for the first requester at or after the round-robin pointer.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    rr_sel_c = rr_ptr_q;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      idx = rr_ptr_q + ID_W'(i);
      if (!found && bus.req_i[idx]) begin
        rr_sel_c = idx;
        found    = 1'b1;
      end
    end
  end

  // Handshake decode; everything is forced quiet while reset is asserted.
  always_comb begin
    sel_c     = (state_q == ARB_HOLD) ? sel_q : rr_sel_c;
    req_c     = rst_n & (((state_q == ARB_IDLE) & (|bus.req_i) & ~fifo_full)
                         | (state_q == ARB_HOLD));
    accept_c  = req_c & bus.gnt_i;
    pop_c     = rst_n & bus.r_valid_i & ~fifo_empty;
    err_set_c = (bus.r_valid_i & fifo_empty)
              | ((state_q == ARB_HOLD) & ~bus.req_i[sel_q]);
  end

  bin_to_onehot #(.BIN_WIDTH(ID_W)) u_sel_oh (
    .bin    (sel_c),
    .onehot (sel_oh)
  );

  bin_to_onehot #(.BIN_WIDTH(ID_W)) u_head_oh (
    .bin    (fifo_head),
    .onehot (head_oh)
  );

  icache_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_c),
    .din   (sel_c),
    .pop   (pop_c),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.req_o     = req_c;
  assign bus.add_o     = rst_n ? bus.add_i[sel_c] : '0;
  assign bus.gnt_o     = accept_c ? sel_oh : '0;
  assign bus.r_valid_o = pop_c ? head_oh : '0;
  assign bus.r_rdata_o = rst_n ? bus.r_rdata_i : '0;

  // Arbitration FSM, round-robin pointer, held selection and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      err_o    <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (req_c && !bus.gnt_i) begin
            state_q <= ARB_HOLD;
            sel_q   <= rr_sel_c;
          end
        end
        ARB_HOLD: begin
          if (bus.gnt_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
      if (accept_c) rr_ptr_q <= sel_c + ID_W'(1);
      if (err_set_c) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_bank_rr_arbiter.sv
// Directed vector bench for icache_bank_rr_arbiter (4 masters, 2 outstanding).
module tb_icache_bank_rr_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int unsigned MO = 2;

  logic clk;
  logic rst_n;
  logic err_o;

  int n_vec;
  int n_bad;

  icache_bank_rr_arbiter_if #(.N_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  icache_bank_rr_arbiter #(
    .N_MASTER        (NM),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err_o (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   req;
    logic         gnt;
    logic         rv;
    logic [127:0] rd;
    logic         e_req;
    logic [3:0]   e_gnt;
    logic [3:0]   e_rv;
    int           e_add;
    logic         e_err;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [AW-1:0] addr_of(input int m);
    return AW'(32'h1000_0000 + m * 32'h40);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the negedge, check combinational and
  // registered outputs mid-cycle, then advance past the next posedge.
  task automatic step(input string nm, input logic [3:0] rq, input logic g,
                      input logic rv, input logic [127:0] rd,
                      input logic e_req, input logic [3:0] e_gnt,
                      input logic [3:0] e_rv, input int e_add, input logic e_err);
    bus.req_i     = rq;
    bus.gnt_i     = g;
    bus.r_valid_i = rv;
    bus.r_rdata_i = rd;
    #2;
    n_vec++;
    chk({nm, ".req_o"},     128'(bus.req_o),     128'(e_req));
    chk({nm, ".gnt_o"},     128'(bus.gnt_o),     128'(e_gnt));
    chk({nm, ".r_valid_o"}, 128'(bus.r_valid_o), 128'(e_rv));
    chk({nm, ".r_rdata_o"}, bus.r_rdata_o,       rd);
    chk({nm, ".err_o"},     128'(err_o),         128'(e_err));
    if (e_add >= 0) chk({nm, ".add_o"}, 128'(bus.add_o), 128'(addr_of(e_add)));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int m = 0; m < int'(NM); m++) bus.add_i[m] = addr_of(m);

    // Rotation, push+pop overlap, single requester, wrap and empty-pop error.
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 128'hD0, 1'b1, 4'b0001, 4'b0000,  0, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 128'hD1, 1'b1, 4'b0010, 4'b0001,  1, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 1'b1, 128'hD2, 1'b1, 4'b0100, 4'b0010,  2, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 1'b1, 128'hD3, 1'b1, 4'b1000, 4'b0100,  3, 1'b0};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 128'hD4, 1'b1, 4'b0001, 4'b1000,  0, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 128'hD5, 1'b0, 4'b0000, 4'b0001, -1, 1'b0};
    tbl[6]  = '{4'b0100, 1'b1, 1'b0, 128'hD6, 1'b1, 4'b0100, 4'b0000,  2, 1'b0};
    tbl[7]  = '{4'b0100, 1'b1, 1'b1, 128'hD7, 1'b1, 4'b0100, 4'b0100,  2, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 128'hD8, 1'b0, 4'b0000, 4'b0100, -1, 1'b0};
    tbl[9]  = '{4'b0011, 1'b1, 1'b0, 128'hD9, 1'b1, 4'b0001, 4'b0000,  0, 1'b0};
    tbl[10] = '{4'b0011, 1'b1, 1'b1, 128'hDA, 1'b1, 4'b0010, 4'b0001,  1, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 128'hDB, 1'b0, 4'b0000, 4'b0010, -1, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 128'hDC, 1'b0, 4'b0000, 4'b0000, -1, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 128'hDD, 1'b0, 4'b0000, 4'b0000, -1, 1'b1};

    // Outputs held at zero while in reset even with everything asserted.
    rst_n         = 1'b0;
    bus.req_i     = 4'b1111;
    bus.gnt_i     = 1'b1;
    bus.r_valid_i = 1'b1;
    bus.r_rdata_i = 128'hFF;
    @(negedge clk);
    #2;
    n_vec++;
    chk("rst.req_o",     128'(bus.req_o),     128'h0);
    chk("rst.gnt_o",     128'(bus.gnt_o),     128'h0);
    chk("rst.r_valid_o", 128'(bus.r_valid_o), 128'h0);
    chk("rst.r_rdata_o", bus.r_rdata_o,       128'h0);
    chk("rst.add_o",     128'(bus.add_o),     128'h0);
    chk("rst.err_o",     128'(err_o),         128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rd,
           tbl[i].e_req, tbl[i].e_gnt, tbl[i].e_rv, tbl[i].e_add, tbl[i].e_err);

    // Clear the sticky error and return rr_ptr to 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Hold under back-pressure; master 3 rising must not steal the held slot.
    step("hold_a", 4'b0110, 1'b0, 1'b0, 128'h0, 1'b1, 4'b0000, 4'b0000, 1, 1'b0);
    step("hold_b", 4'b0110, 1'b0, 1'b0, 128'h0, 1'b1, 4'b0000, 4'b0000, 1, 1'b0);
    step("hold_c", 4'b1110, 1'b0, 1'b0, 128'h0, 1'b1, 4'b0000, 4'b0000, 1, 1'b0);
    step("hold_g", 4'b1110, 1'b1, 1'b0, 128'h0, 1'b1, 4'b0010, 4'b0000, 1, 1'b0);
    step("next_2", 4'b1110, 1'b1, 1'b0, 128'h0, 1'b1, 4'b0100, 4'b0000, 2, 1'b0);
    // FIFO full: request masked, a pop in the same cycle does not unmask it.
    step("full_a", 4'b1110, 1'b1, 1'b0, 128'h0, 1'b0, 4'b0000, 4'b0000, -1, 1'b0);
    step("full_p", 4'b1110, 1'b1, 1'b1, 128'hA1, 1'b0, 4'b0000, 4'b0010, -1, 1'b0);
    step("full_r", 4'b1110, 1'b1, 1'b0, 128'h0, 1'b1, 4'b1000, 4'b0000, 3, 1'b0);
    step("drain0", 4'b0000, 1'b0, 1'b1, 128'hB2, 1'b0, 4'b0000, 4'b0100, -1, 1'b0);
    step("drain1", 4'b0000, 1'b0, 1'b1, 128'hC3, 1'b0, 4'b0000, 4'b1000, -1, 1'b0);

    // Out-of-order masters, in-order data.
    step("ooo_g3", 4'b1000, 1'b1, 1'b0, 128'h0, 1'b1, 4'b1000, 4'b0000, 3, 1'b0);
    step("ooo_g1", 4'b0010, 1'b1, 1'b0, 128'h0, 1'b1, 4'b0010, 4'b0000, 1, 1'b0);
    step("ooo_dA", 4'b0000, 1'b0, 1'b1, 128'hA, 1'b0, 4'b0000, 4'b1000, -1, 1'b0);
    step("ooo_dB", 4'b0000, 1'b0, 1'b1, 128'hB, 1'b0, 4'b0000, 4'b0010, -1, 1'b0);

    // Requester drops during HOLD: error flagged, request stays held.
    step("drop_a", 4'b0001, 1'b0, 1'b0, 128'h0, 1'b1, 4'b0000, 4'b0000, 0, 1'b0);
    step("drop_b", 4'b0000, 1'b0, 1'b0, 128'h0, 1'b1, 4'b0000, 4'b0000, 0, 1'b0);
    step("drop_c", 4'b0000, 1'b0, 1'b0, 128'h0, 1'b1, 4'b0000, 4'b0000, 0, 1'b1);

    // Asynchronous reset in the middle of HOLD.
    bus.req_i     = 4'b1111;
    bus.gnt_i     = 1'b1;
    bus.r_valid_i = 1'b1;
    bus.r_rdata_i = 128'h55;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("arst.req_o",     128'(bus.req_o),     128'h0);
    chk("arst.gnt_o",     128'(bus.gnt_o),     128'h0);
    chk("arst.r_valid_o", 128'(bus.r_valid_o), 128'h0);
    chk("arst.err_o",     128'(err_o),         128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_g", 4'b1111, 1'b1, 1'b0, 128'h0, 1'b1, 4'b0001, 4'b0000, 0, 1'b0);
    step("post_r", 4'b0000, 1'b0, 1'b1, 128'h7, 1'b0, 4'b0000, 4'b0001, -1, 1'b0);
    step("post_e", 4'b0000, 1'b0, 1'b0, 128'h0, 1'b0, 4'b0000, 4'b0000, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
